// File: rtl/instr_fetch_stage.sv
// IF stage for the 32-bit MIPS-style datapath: PC, req/ack instruction fetch,
// IF/ID pipeline register with a one-entry skid buffer and redirect flush.
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4,
  output logic [5:0]  id_opcode,
  output logic [4:0]  id_rs,
  output logic [4:0]  id_rt,
  output logic [4:0]  id_rd,
  output logic [15:0] id_imm16
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_FETCH   = 2'd1;
  localparam logic [1:0] S_HOLD    = 2'd2;
  localparam logic [1:0] S_DISCARD = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc4_q, id_pc4_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc4_q, skid_pc4_d;
  logic [31:0] disc_addr_q, disc_addr_d;

  logic [31:0] pc_plus4;
  logic [31:0] redir_pc;
  logic        if_free;

  assign pc_plus4 = pc_q + 32'd4;
  assign redir_pc = redirect_pc & 32'hFFFF_FFFC;
  assign if_free  = !id_valid_q || !stall;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    id_valid_d   = id_valid_q;
    id_instr_d   = id_instr_q;
    id_pc4_d     = id_pc4_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;
    disc_addr_d  = disc_addr_q;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (redirect) begin
          id_valid_d = 1'b0;
          pc_d       = redir_pc;
          // An unanswered request must still be drained at its old address.
          if (!imem_ack) begin
            state_d     = S_DISCARD;
            disc_addr_d = pc_q;
          end
        end else if (imem_ack) begin
          pc_d = pc_plus4;
          if (if_free) begin
            id_valid_d = 1'b1;
            id_instr_d = imem_rdata;
            id_pc4_d   = pc_plus4;
          end else begin
            skid_instr_d = imem_rdata;
            skid_pc4_d   = pc_plus4;
            state_d      = S_HOLD;
          end
        end else if (if_free) begin
          id_valid_d = 1'b0;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          id_valid_d = 1'b0;
          pc_d       = redir_pc;
          state_d    = S_FETCH;
        end else if (!stall) begin
          id_valid_d = 1'b1;
          id_instr_d = skid_instr_q;
          id_pc4_d   = skid_pc4_q;
          state_d    = S_FETCH;
        end
      end
      S_DISCARD: begin
        if (redirect) begin
          id_valid_d = 1'b0;
          pc_d       = redir_pc;
        end
        // The dropped ack closes the old request; pc already holds the target.
        if (imem_ack) state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      id_valid_q   <= 1'b0;
      id_instr_q   <= '0;
      id_pc4_q     <= '0;
      skid_instr_q <= '0;
      skid_pc4_q   <= '0;
      disc_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      id_valid_q   <= id_valid_d;
      id_instr_q   <= id_instr_d;
      id_pc4_q     <= id_pc4_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
      disc_addr_q  <= disc_addr_d;
    end
  end

  assign imem_req    = (state_q == S_FETCH) || (state_q == S_DISCARD);
  assign imem_addr   = (state_q == S_DISCARD) ? disc_addr_q : pc_q;
  assign id_valid    = id_valid_q;
  assign id_instr    = id_instr_q;
  assign id_pc_plus4 = id_pc4_q;
  assign id_opcode   = id_instr_q[31:26];
  assign id_rs       = id_instr_q[25:21];
  assign id_rt       = id_instr_q[20:16];
  assign id_rd       = id_instr_q[15:11];
  assign id_imm16    = id_instr_q[15:0];

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage: a small latency-programmable memory
// responder plus a linear sequence of hand-computed checks.
module tb_instr_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus4;
  logic [5:0]  id_opcode;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [15:0] id_imm16;

  int n_checks = 0;
  int n_fail   = 0;

  int          lat;
  int          wcnt;
  logic        fixed_data;

  instr_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc_plus4(id_pc_plus4),
    .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_imm16(id_imm16)
  );

  always #5 clk = ~clk;

  // Memory answers after `lat` wait cycles of a held request.
  assign imem_ack   = imem_req && (wcnt >= lat);
  assign imem_rdata = fixed_data ? 32'h2108_FFFC : (imem_addr ^ 32'hA5A5_0000);

  always @(posedge clk) begin
    if (reset || !imem_req || imem_ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    lat = 0; fixed_data = 1'b0; wcnt = 0;
    step(); step();
    // Reset state (IDLE)
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, id_valid}, 32'd0);
    check("rst_instr", id_instr, 32'd0);
    check("rst_pc4", id_pc_plus4, 32'd0);
    reset = 1'b0;

    // Zero-wait streaming
    step();
    check("zw_req0", {31'd0, imem_req}, 32'd1);
    check("zw_addr0", imem_addr, 32'h0);
    step();
    check("zw_valid1", {31'd0, id_valid}, 32'd1);
    check("zw_pc4_1", id_pc_plus4, 32'd4);
    check("zw_instr1", id_instr, 32'hA5A5_0000);
    check("zw_addr1", imem_addr, 32'h4);
    step();
    check("zw_pc4_2", id_pc_plus4, 32'd8);
    check("zw_instr2", id_instr, 32'hA5A5_0004);
    check("zw_addr2", imem_addr, 32'h8);
    step();
    check("zw_pc4_3", id_pc_plus4, 32'd12);
    check("zw_valid3", {31'd0, id_valid}, 32'd1);
    check("zw_addr3", imem_addr, 32'hC);

    // Stall for four cycles: word at 0xC goes to skid, HOLD issues nothing
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("st_pc4", id_pc_plus4, 32'd12);
      check("st_instr", id_instr, 32'hA5A5_0008);
      check("st_valid", {31'd0, id_valid}, 32'd1);
      check("st_req", {31'd0, imem_req}, 32'd0);
    end
    stall = 1'b0;
    step();
    check("sk_pc4", id_pc_plus4, 32'd16);
    check("sk_instr", id_instr, 32'hA5A5_000C);
    check("sk_req", {31'd0, imem_req}, 32'd1);
    check("sk_addr", imem_addr, 32'h10);
    step();
    check("rs_pc4", id_pc_plus4, 32'd20);
    check("rs_instr", id_instr, 32'hA5A5_0010);
    check("rs_addr", imem_addr, 32'h14);

    // Three wait states, fixed instruction word
    lat = 3; fixed_data = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("ws_addr", imem_addr, 32'h14);
      check("ws_valid", {31'd0, id_valid}, 32'd0);
    end
    step();
    fixed_data = 1'b0;
    check("ws_valid_pulse", {31'd0, id_valid}, 32'd1);
    check("ws_opcode", {26'd0, id_opcode}, 32'h08);
    check("ws_rs", {27'd0, id_rs}, 32'd8);
    check("ws_rt", {27'd0, id_rt}, 32'd8);
    check("ws_rd", {27'd0, id_rd}, 32'h1F);
    check("ws_imm", {16'd0, id_imm16}, 32'hFFFC);
    check("ws_pc4", id_pc_plus4, 32'h18);
    check("ws_addr_next", imem_addr, 32'h18);

    // Redirect while the request to 0x18 is waiting
    step();
    check("rd_bubble", {31'd0, id_valid}, 32'd0);
    redirect = 1'b1; redirect_pc = 32'h0000_0403;
    step();
    redirect = 1'b0;
    check("rd_valid", {31'd0, id_valid}, 32'd0);
    check("rd_req_hold", {31'd0, imem_req}, 32'd1);
    check("rd_old_addr", imem_addr, 32'h18);
    step();
    check("rd_old_addr2", imem_addr, 32'h18);
    step();
    check("rd_new_addr", imem_addr, 32'h400);
    check("rd_req_new", {31'd0, imem_req}, 32'd1);
    check("rd_dropped", {31'd0, id_valid}, 32'd0);
    lat = 0;
    step();
    check("rd_tgt_valid", {31'd0, id_valid}, 32'd1);
    check("rd_tgt_pc4", id_pc_plus4, 32'h404);
    check("rd_tgt_instr", id_instr, 32'hA5A5_0400);

    // Redirect coinciding with ack and stall
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0800;
    step();
    stall = 1'b0; redirect = 1'b0;
    check("ra_flush", {31'd0, id_valid}, 32'd0);
    check("ra_addr", imem_addr, 32'h800);
    check("ra_req", {31'd0, imem_req}, 32'd1);
    step();
    check("ra_pc4", id_pc_plus4, 32'h804);
    check("ra_instr", id_instr, 32'hA5A5_0800);

    // Wrap-around; low redirect bits are masked
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFD;
    step();
    redirect = 1'b0;
    check("wr_addr", imem_addr, 32'hFFFF_FFFC);
    step();
    check("wr_pc4", id_pc_plus4, 32'h0);
    check("wr_instr", id_instr, 32'h5A5A_FFFC);
    check("wr_next_addr", imem_addr, 32'h0);

    // Reset in the middle of a wait at pc 0x20
    redirect = 1'b1; redirect_pc = 32'h0000_0020;
    step();
    redirect = 1'b0; lat = 3;
    check("mr_addr", imem_addr, 32'h20);
    step();
    reset = 1'b1;
    step();
    check("mr_req", {31'd0, imem_req}, 32'd0);
    check("mr_valid", {31'd0, id_valid}, 32'd0);
    check("mr_instr", id_instr, 32'd0);
    check("mr_pc4", id_pc_plus4, 32'd0);
    check("mr_addr_rst", imem_addr, 32'd0);
    reset = 1'b0; lat = 0;
    step();
    check("mr_first_req", {31'd0, imem_req}, 32'd1);
    check("mr_first_addr", imem_addr, 32'd0);
    step();
    check("mr_first_pc4", id_pc_plus4, 32'd4);
    check("mr_first_valid", {31'd0, id_valid}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
